// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD minutes:seconds timer.
// Holds the FSM state encoding, BCD limits and the preset clamp helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_e;

  localparam logic [3:0] BCD_BLANK        = 4'hF;
  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  // Out-of-range preset digits saturate to the digit's own maximum.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One up/down BCD digit that wraps at LIMIT/0 and reports the wrap to the next digit.
// Also exposes its next value so the parent can register display outputs in step.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter logic [3:0] LIMIT = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic [3:0] digit_nxt,
  output logic       carry_borrow_out
);

  logic [3:0] digit_q, digit_d;

  // Kept independent of load so the parent can use it to decide whether to load.
  assign carry_borrow_out = en && (up ? (digit_q == LIMIT) : (digit_q == 4'd0));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (en) begin
      if (up) begin
        digit_d = (digit_q == LIMIT) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == 4'd0) ? LIMIT : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign digit_nxt = digit_d;

endmodule

// File: rtl/bcd_mmss_timer.sv
// MM:SS BCD timer core: run/pause FSM, 1 Hz prescaler, up/down count with expiry and blink.
// Display outputs are registered from next-state values so they track the internal state exactly.
module bcd_mmss_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       load,
  input  logic       up_dn,
  input  logic [3:0] preset_m1,
  input  logic [3:0] preset_m0,
  input  logic [3:0] preset_s1,
  input  logic [3:0] preset_s0,
  output logic [3:0] dig_m1,
  output logic [3:0] dig_m0,
  output logic [3:0] dig_s1,
  output logic [3:0] dig_s0,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [3:0] cnt_m1, cnt_m0, cnt_s1, cnt_s0;
  logic [3:0] nxt_m1, nxt_m0, nxt_s1, nxt_s0;
  logic [3:0] val_m1, val_m0, val_s1, val_s0;
  logic       cb_s0, cb_s1, cb_m0, cb_m1;

  logic tick, wrap, reload, cnt_load, at_zero, at_one, expire, blank_d;

  assign tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign at_zero = {cnt_m1, cnt_m0, cnt_s1, cnt_s0} == 16'h0000;
  assign at_one  = {cnt_m1, cnt_m0, cnt_s1, cnt_s0} == 16'h0001;

  // A carry/borrow out of the minutes-tens digit means the step would wrap
  // past 99:59 or below 00:00; the count is then reloaded with itself to hold.
  assign wrap     = cb_m1;
  assign reload   = load || ((state_q == EXPIRED) && start_stop);
  assign cnt_load = reload || wrap;
  assign expire   = tick && (wrap || (!up_dn && at_one));

  assign val_m1 = reload ? bcd_clamp(preset_m1, BCD_MAX_UNITS)    : cnt_m1;
  assign val_m0 = reload ? bcd_clamp(preset_m0, BCD_MAX_UNITS)    : cnt_m0;
  assign val_s1 = reload ? bcd_clamp(preset_s1, BCD_MAX_TENS_SEC) : cnt_s1;
  assign val_s0 = reload ? bcd_clamp(preset_s0, BCD_MAX_UNITS)    : cnt_s0;

  bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_s0 (
    .clk(clk), .rst_n(rst_n), .en(tick), .up(up_dn), .load(cnt_load),
    .load_val(val_s0), .digit(cnt_s0), .digit_nxt(nxt_s0), .carry_borrow_out(cb_s0)
  );

  bcd_digit_counter #(.LIMIT(BCD_MAX_TENS_SEC)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en(cb_s0), .up(up_dn), .load(cnt_load),
    .load_val(val_s1), .digit(cnt_s1), .digit_nxt(nxt_s1), .carry_borrow_out(cb_s1)
  );

  bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_m0 (
    .clk(clk), .rst_n(rst_n), .en(cb_s1), .up(up_dn), .load(cnt_load),
    .load_val(val_m0), .digit(cnt_m0), .digit_nxt(nxt_m0), .carry_borrow_out(cb_m0)
  );

  bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_m1 (
    .clk(clk), .rst_n(rst_n), .en(cb_m0), .up(up_dn), .load(cnt_load),
    .load_val(val_m1), .digit(cnt_m1), .digit_nxt(nxt_m1), .carry_borrow_out(cb_m1)
  );

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_stop && !(!up_dn && at_zero)) state_d = RUN;
        RUN:     if (expire) state_d = EXPIRED;
                 else if (start_stop) state_d = PAUSE;
        PAUSE:   if (start_stop) state_d = RUN;
        EXPIRED: if (start_stop) state_d = IDLE;
      endcase
    end
  end

  // The prescaler holds on the pause edge so a resume continues mid-second.
  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE:    presc_d = '0;
        RUN:     if (tick) presc_d = '0;
                 else if (!start_stop) presc_d = presc_q + PW'(1);
        PAUSE:   presc_d = presc_q;
        EXPIRED: if (start_stop || presc_q == PRESC_LAST) presc_d = '0;
                 else presc_d = presc_q + PW'(1);
      endcase
    end
  end

  assign blank_d = (state_d == EXPIRED) && (presc_d < PRESC_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      dig_m1  <= 4'd0;
      dig_m0  <= 4'd0;
      dig_s1  <= 4'd0;
      dig_s0  <= 4'd0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dig_m1  <= blank_d ? BCD_BLANK : nxt_m1;
      dig_m0  <= blank_d ? BCD_BLANK : nxt_m0;
      dig_s1  <= blank_d ? BCD_BLANK : nxt_s1;
      dig_s0  <= blank_d ? BCD_BLANK : nxt_s0;
      running <= (state_d == RUN);
      expired <= (state_d == EXPIRED);
      done    <= (state_d == EXPIRED) && (state_q != EXPIRED);
    end
  end

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Self-checking bench for bcd_mmss_timer: vector table, directed corner sequences and
// random stimulus against a reference model that keeps the count as plain total seconds.
module tb_bcd_mmss_timer;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0, load = 1'b0, up_dn = 1'b0;
  logic [3:0] preset_m1 = '0, preset_m0 = '0, preset_s1 = '0, preset_s0 = '0;
  logic [3:0] dig_m1, dig_m0, dig_s1, dig_s0;
  logic       running, expired, done;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_p, m_t;
  bit m_done;

  bcd_mmss_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .load(load), .up_dn(up_dn),
    .preset_m1(preset_m1), .preset_m0(preset_m0), .preset_s1(preset_s1), .preset_s0(preset_s0),
    .dig_m1(dig_m1), .dig_m0(dig_m0), .dig_s1(dig_s1), .dig_s0(dig_s0),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int preset_total();
    int m, s;
    m = min_i(int'(preset_m1), 9) * 10 + min_i(int'(preset_m0), 9);
    s = min_i(int'(preset_s1), 5) * 10 + min_i(int'(preset_s0), 9);
    return m * 60 + s;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_p = 0; m_t = 0; m_done = 0;
  endtask

  // Reference: count is total seconds 0..5999; one tick every TD cycles in RUN.
  task automatic model_edge();
    int  old_st = m_st;
    bit  tk     = (m_st == M_RUN) && (m_p == TD - 1);
    if (load) begin
      m_t = preset_total(); m_st = M_IDLE; m_p = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          m_p = 0;
          if (start_stop && !(!up_dn && m_t == 0)) m_st = M_RUN;
        end
        M_RUN: begin
          if (tk) begin
            m_p = 0;
            if (up_dn ? (m_t == 5999) : (m_t <= 1)) begin
              if (!up_dn) m_t = 0;
              m_st = M_EXP;
            end else begin
              m_t = up_dn ? m_t + 1 : m_t - 1;
              if (start_stop) m_st = M_PAUSE;
            end
          end else if (start_stop) m_st = M_PAUSE;
          else m_p++;
        end
        M_PAUSE: if (start_stop) m_st = M_RUN;
        default: begin
          if (start_stop) begin
            m_t = preset_total(); m_st = M_IDLE; m_p = 0;
          end else m_p = (m_p + 1) % TD;
        end
      endcase
    end
    m_done = (m_st == M_EXP) && (old_st != M_EXP);
  endtask

  function automatic logic [18:0] model_out();
    int m = m_t / 60;
    int s = m_t % 60;
    logic [15:0] d = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    if (m_st == M_EXP && m_p < TD / 2) d = 16'hFFFF;
    return {d, m_st == M_RUN, m_st == M_EXP, m_done};
  endfunction

  function automatic logic [18:0] dut_out();
    return {dig_m1, dig_m0, dig_s1, dig_s0, running, expired, done};
  endfunction

  function automatic logic [15:0] digs();
    return {dig_m1, dig_m0, dig_s1, dig_s0};
  endfunction

  task automatic set_preset(input logic [15:0] p);
    {preset_m1, preset_m0, preset_s1, preset_s0} = p;
  endtask

  // Drive pulses at the falling edge, clock once, compare at the next falling edge.
  task automatic step(input bit ss, input bit ld);
    start_stop = ss;
    load       = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 32'(dut_out()), 32'(model_out()));
    start_stop = 1'b0;
    load       = 1'b0;
  endtask

  typedef struct {
    bit          ss;
    bit          ld;
    bit          up;
    logic [15:0] preset;
    logic [15:0] exp_dig;
    bit          exp_run;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, i_exp, done_cnt;

    vecs[0] = '{ss: 0, ld: 1, up: 0, preset: 16'h1C7A, exp_dig: 16'h1959, exp_run: 0};
    vecs[1] = '{ss: 1, ld: 0, up: 0, preset: 16'h0000, exp_dig: 16'h1959, exp_run: 1};
    vecs[2] = '{ss: 1, ld: 1, up: 0, preset: 16'h0000, exp_dig: 16'h0000, exp_run: 0};
    vecs[3] = '{ss: 1, ld: 0, up: 0, preset: 16'h0000, exp_dig: 16'h0000, exp_run: 0};
    vecs[4] = '{ss: 1, ld: 0, up: 1, preset: 16'h0000, exp_dig: 16'h0000, exp_run: 1};
    vecs[5] = '{ss: 0, ld: 1, up: 1, preset: 16'h1234, exp_dig: 16'h1234, exp_run: 0};

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'd0);
    rst_n = 1'b1;

    // Vector table: clamp, load/start priority, zero-start ignore
    foreach (vecs[i]) begin
      up_dn = vecs[i].up;
      set_preset(vecs[i].preset);
      step(vecs[i].ss, vecs[i].ld);
      check($sformatf("vec%0d_dig_run", i), 32'({digs(), running}),
            32'({vecs[i].exp_dig, vecs[i].exp_run}));
    end

    // Reset mid-run, no clock edge required
    up_dn = 1'b0;
    set_preset(16'h1234);
    step(0, 1);
    step(1, 0);
    step(0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Down expiry from 01:00 with blink
    set_preset(16'h0100);
    step(0, 1);
    step(1, 0);
    repeat (TD) step(0, 0);
    check("down_first_tick", 32'(digs()), 32'h0059);
    n = 0;
    while (!expired && n < 400) begin
      step(0, 0);
      n++;
    end
    check("down_expired", 32'(expired), 32'd1);
    check("down_steps", 32'(n), 32'(59 * TD));
    check("done_on_entry", 32'(done), 32'd1);
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      i_exp = ((i % 4) < 2) ? 32'hFFFF : 32'h0000;
      check($sformatf("blink%0d", i), 32'(digs()), 32'(i_exp));
      if (done) done_cnt++;
    end
    check("done_single", 32'(done_cnt), 32'd0);

    // Up carries and 99:59 hold
    up_dn = 1'b1;
    set_preset(16'h0959);
    step(0, 1);
    step(1, 0);
    repeat (TD) step(0, 0);
    check("up_carry", 32'(digs()), 32'h1000);
    set_preset(16'h9959);
    step(0, 1);
    step(1, 0);
    repeat (TD) step(0, 0);
    check("up_expired", 32'({expired, done}), 32'b11);
    repeat (2) step(0, 0);
    check("up_hold_9959", 32'(digs()), 32'h9959);

    // Pause when prescaler is 2, hold 20 cycles, resume
    up_dn = 1'b0;
    set_preset(16'h0500);
    step(0, 1);
    step(1, 0);
    repeat (2) step(0, 0);
    step(1, 0);
    repeat (20) step(0, 0);
    check("pause_hold", 32'({digs(), running}), 32'({16'h0500, 1'b0}));
    step(1, 0);
    step(0, 0);
    check("resume_pre_tick", 32'(digs()), 32'h0500);
    step(0, 0);
    check("resume_tick", 32'(digs()), 32'h0459);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      bit ss, ld;
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      ld = ($urandom_range(0, 59) == 0);
      ss = ($urandom_range(0, 9) == 0);
      if (ld) begin
        if ($urandom_range(0, 3) == 0) begin
          set_preset({4'd9, 4'd9, 4'd5, 4'($urandom_range(0, 15))});
        end else begin
          set_preset({4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15))});
        end
      end
      step(ss, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_mmss_timer.md
Name: bcd_mmss_timer

Overview:
- Sequential counting core of the digital timer.
- Keeps a minutes:seconds count (00:00–99:59) as four BCD digits and counts up or down at 1 Hz.
- Supports preset load, start/pause, expiry detection and an expiry blink.
- Each digit output drives one seg7 decoder directly. Value 4'hF blanks that display through the decoder's off code.

Parameters:
- TICK_DIV, 50000000, clock cycles per count step (1 s at 50 MHz); must be ≥2 and even.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
- load  input  1  single-cycle pulse; loads the preset and returns to IDLE.
- up_dn  input  1  1 = count up, 0 = count down; sampled on every tick.
- preset_m1, preset_m0, preset_s1, preset_s0  input  4 each  BCD preset digits (minutes tens/units, seconds tens/units).
- dig_m1, dig_m0, dig_s1, dig_s0  output  4 each  registered BCD digits to the seg7 instances; 4'hF = blank.
- running  output  1  high in RUN.
- expired  output  1  high in EXPIRED.
- done  output  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, count = 00:00, prescaler = 0.
  - All dig_* = 0; running, expired and done = 0.
  - Applies immediately, including mid-run.
- Prescaler: counts 0..TICK_DIV-1.
  - tick is asserted when the prescaler equals TICK_DIV-1 in RUN, then the prescaler wraps to 0.
  - Holds its value in PAUSE.
  - Cleared to 0 on load, on IDLE→RUN, and on entry to EXPIRED.
  - Free-runs in EXPIRED to time the blink.
- Count step on tick, with the new digits visible the cycle after the tick cycle:
  - Down: s0 9→0 then borrow; s1 5→0 then borrow; m0 9→0 then borrow; m1 9→0.
  - Up is the mirror: s0 wraps 9→0 with carry, s1 wraps 5→0, m0 wraps 9→0, m1 increments.
- Preset sanitising on load:
  - preset_s1 > 5 is loaded as 5.
  - Any other preset digit > 9 is loaded as 9.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE + start_stop → RUN, except in down mode with count 00:00, where the pulse is ignored and the state stays IDLE.
  - RUN + start_stop → PAUSE.
  - RUN, down mode, tick producing 00:00 → EXPIRED. Display shows 00:00.
  - RUN, up mode, tick while count = 99:59 → EXPIRED. Count holds 99:59; no wrap.
  - PAUSE + start_stop → RUN. Prescaler resumes from its held value.
  - EXPIRED + start_stop or load → IDLE with the preset loaded.
  - Any state + load → IDLE with the preset loaded.
- Simultaneous events:
  - load has priority over start_stop in the same cycle.
  - start_stop in the same cycle as tick: the tick's count step is applied, then the state moves to PAUSE.
- done: high exactly one cycle, registered, in the first cycle that expired is high.
- Blink in EXPIRED:
  - While prescaler < TICK_DIV/2, all dig_* = 4'hF (blank).
  - Otherwise dig_* show the held count.
  - In all other states dig_* show the count.
- up_dn changes during RUN take effect at the next tick only.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, EXPIRED).
  - BCD_BLANK = 4'hF, BCD_MAX_UNITS = 9, BCD_MAX_TENS_SEC = 5.
- Sub-module bcd_digit_counter, instantiated four times:
  - Parameter: limit.
  - Inputs: en, up, load, load_val.
  - Outputs: digit, carry_borrow_out (asserted when wrapping at limit/0 with en).
  - The top level chains carry_borrow_out into the next digit's en and holds the FSM, prescaler, 99:59 / 00:00 detection, clamp and blink mux.

Test Plan (TICK_DIV = 4):
- Reset mid-run: with count 12:34 in RUN, drop rst_n → all dig_* = 0, running = 0, expired = 0 immediately (no clock edge needed).
- Down expiry:
  - Preset 01:00, load, start_stop → after 1 tick, 00:59.
  - After 60 ticks, 00:00, expired = 1, done high exactly one cycle.
  - Blink: dig_* = F for 2 cycles, then 0 for 2 cycles, repeating.
- Up carries:
  - Preset 09:59, up mode, run 1 tick → 10:00.
  - Preset 99:59, 1 tick → expired, display holds 99:59 (non-blank phase), no wrap to 00:00.
- Pause/resume:
  - start_stop when prescaler = 2 → digits and prescaler hold for 20 cycles.
  - start_stop again → next tick occurs 2 cycles later (prescaler resumes from 2).
- Clamp and priority:
  - Preset 1,12,7,10 loaded → 1,9,5,9.
  - load and start_stop in the same cycle → state IDLE, running = 0.
- Zero start ignored: down mode, count 00:00, start_stop → stays IDLE, running = 0, no done.
